trg_shaper: RTL and testbench

Multi-channel trigger conditioner. Converts each of NCH raw trigger inputs into a clean output pulse of programmable width, followed by a programmable dead time. During the dead time further triggers on that channel are rejected and counted. The block sits between the trigger input pins/synchronisers and the ALPIDE trigger sequencer. It generalises the fixed 4-cycle-pulse / 3-cycle-holdoff conditioner to per-design channel count, runtime width and dead time, edge or level mode, and accept/reject statistics.

---
 rtl/trg_shaper_if.sv | 42 ++++
 rtl/trg_shaper.sv | 139 +++++++++++++
 tb/tb_trg_shaper.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/trg_shaper_if.sv
// ---------------------------------------------------------------------------
// trg_shaper_if
// Bundles the trigger conditioner's per-channel inputs, configuration and
// status outputs. Clock and reset stay outside as plain ports.
//   trg_i        raw trigger per channel (already synchronous)
//   en_i         per-channel accept enable
//   edge_mode_i  1 = accept on rising edge, 0 = accept on level high
//   width_i      pulse length in cycles (0 treated as 1)
//   dead_i       holdoff after pulse in cycles (0 allowed)
//   cnt_clr_i    synchronous clear of all statistics counters
//   trg_o        conditioned trigger pulse per channel
//   busy_o       channel in pulse or dead time
//   acc_cnt_o    accepted-trigger counters, channel c at [c*CW +: CW]
//   rej_cnt_o    rejected-trigger counters, same packing
// master: the driver of triggers/configuration; slave: the conditioner.
// ---------------------------------------------------------------------------
interface trg_shaper_if #(
    parameter int NCH = 4,
    parameter int WW  = 8,
    parameter int CW  = 16
);
    logic [NCH-1:0]    trg_i;
    logic [NCH-1:0]    en_i;
    logic              edge_mode_i;
    logic [WW-1:0]     width_i;
    logic [WW-1:0]     dead_i;
    logic              cnt_clr_i;
    logic [NCH-1:0]    trg_o;
    logic [NCH-1:0]    busy_o;
    logic [NCH*CW-1:0] acc_cnt_o;
    logic [NCH*CW-1:0] rej_cnt_o;

    modport master (
        output trg_i, en_i, edge_mode_i, width_i, dead_i, cnt_clr_i,
        input  trg_o, busy_o, acc_cnt_o, rej_cnt_o
    );

    modport slave (
        input  trg_i, en_i, edge_mode_i, width_i, dead_i, cnt_clr_i,
        output trg_o, busy_o, acc_cnt_o, rej_cnt_o
    );
endinterface

// File: rtl/trg_shaper.sv
// ---------------------------------------------------------------------------
// trg_shaper
// Multi-channel trigger conditioner. Each channel turns an accepted raw
// trigger into a pulse of max(width_i,1) cycles followed by dead_i cycles of
// holdoff. Rising edges arriving while the channel is busy are counted as
// rejects; accepts are counted too. Both counters saturate.
// Ports:
//   clk_i    single clock, rising edge
//   rst_n_i  asynchronous active-low reset
//   bus      trg_shaper_if.slave (triggers, config, pulse/busy, counters)
// ---------------------------------------------------------------------------
module trg_shaper #(
    parameter int NCH = 4,
    parameter int WW  = 8,
    parameter int CW  = 16
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    trg_shaper_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, PULSE, DEAD} state_t;

    state_t            state     [NCH];
    state_t            state_nxt [NCH];
    logic [WW-1:0]     cnt       [NCH];
    logic [WW-1:0]     cnt_nxt   [NCH];
    logic [WW-1:0]     dead_q    [NCH];
    logic [WW-1:0]     dead_nxt  [NCH];

    logic [NCH-1:0]    trg_q;
    logic [NCH-1:0]    rise;
    logic [NCH-1:0]    accept;
    logic [NCH-1:0]    reject;
    logic [NCH-1:0]    trg_r;
    logic [NCH-1:0]    busy_r;
    logic [NCH*CW-1:0] acc_q;
    logic [NCH*CW-1:0] rej_q;
    logic [WW-1:0]     width_m1;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (&v) ? v : v + CW'(1);
    endfunction

    assign rise     = bus.trg_i & ~trg_q;
    // A zero width still produces a one-cycle pulse.
    assign width_m1 = (bus.width_i == '0) ? '0 : bus.width_i - WW'(1);

    always_comb begin
        for (int c = 0; c < NCH; c++) begin
            accept[c] = (state[c] == IDLE) && bus.en_i[c] &&
                        (bus.edge_mode_i ? rise[c] : bus.trg_i[c]);
            // Only edges count as rejects; a held level is not a new trigger.
            reject[c] = (state[c] != IDLE) && rise[c];
        end
    end

    always_comb begin
        for (int c = 0; c < NCH; c++) begin
            state_nxt[c] = state[c];
            cnt_nxt[c]   = cnt[c];
            dead_nxt[c]  = dead_q[c];
            case (state[c])
                IDLE: begin
                    if (accept[c]) begin
                        state_nxt[c] = PULSE;
                        cnt_nxt[c]   = width_m1;
                        dead_nxt[c]  = bus.dead_i;
                    end
                end
                PULSE: begin
                    if (cnt[c] == '0) begin
                        if (dead_q[c] == '0) begin
                            state_nxt[c] = IDLE;
                        end else begin
                            state_nxt[c] = DEAD;
                            cnt_nxt[c]   = dead_q[c] - WW'(1);
                        end
                    end else begin
                        cnt_nxt[c] = cnt[c] - WW'(1);
                    end
                end
                DEAD: begin
                    if (cnt[c] == '0) begin
                        state_nxt[c] = IDLE;
                    end else begin
                        cnt_nxt[c] = cnt[c] - WW'(1);
                    end
                end
                default: state_nxt[c] = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int c = 0; c < NCH; c++) begin
                state[c]  <= IDLE;
                cnt[c]    <= '0;
                dead_q[c] <= '0;
            end
            trg_q  <= '0;
            trg_r  <= '0;
            busy_r <= '0;
        end else begin
            for (int c = 0; c < NCH; c++) begin
                state[c]  <= state_nxt[c];
                cnt[c]    <= cnt_nxt[c];
                dead_q[c] <= dead_nxt[c];
                // Outputs follow the current state, one cycle behind it.
                trg_r[c]  <= (state[c] == PULSE);
                busy_r[c] <= (state[c] != IDLE);
            end
            trg_q <= bus.trg_i;
        end
    end

    // Statistics; clear wins over a same-cycle increment.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            acc_q <= '0;
            rej_q <= '0;
        end else if (bus.cnt_clr_i) begin
            acc_q <= '0;
            rej_q <= '0;
        end else begin
            for (int c = 0; c < NCH; c++) begin
                if (accept[c]) acc_q[c*CW +: CW] <= sat_inc(acc_q[c*CW +: CW]);
                if (reject[c]) rej_q[c*CW +: CW] <= sat_inc(rej_q[c*CW +: CW]);
            end
        end
    end

    assign bus.trg_o     = trg_r;
    assign bus.busy_o    = busy_r;
    assign bus.acc_cnt_o = acc_q;
    assign bus.rej_cnt_o = rej_q;

endmodule

// File: tb/tb_trg_shaper.sv
// ---------------------------------------------------------------------------
// tb_trg_shaper
// Directed bench for trg_shaper with NCH=4, WW=8, CW=4 (small counters so
// saturation is reachable). Inputs change and outputs are sampled 1 ns after
// each rising clock edge.
// ---------------------------------------------------------------------------
module tb_trg_shaper;

    localparam int NCH = 4;
    localparam int WW  = 8;
    localparam int CW  = 4;

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    trg_shaper_if #(.NCH(NCH), .WW(WW), .CW(CW)) ifc ();

    trg_shaper #(.NCH(NCH), .WW(WW), .CW(CW)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (ifc.slave)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [CW-1:0] acc_of(input int c);
        return ifc.acc_cnt_o[c*CW +: CW];
    endfunction

    function automatic logic [CW-1:0] rej_of(input int c);
        return ifc.rej_cnt_o[c*CW +: CW];
    endfunction

    task automatic clear_counters();
        ifc.cnt_clr_i = 1'b1;
        tick();
        ifc.cnt_clr_i = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n           = 1'b0;
        ifc.trg_i       = '0;
        ifc.en_i        = 4'hF;
        ifc.edge_mode_i = 1'b0;
        ifc.width_i     = 8'd4;
        ifc.dead_i      = 8'd3;
        ifc.cnt_clr_i   = 1'b0;

        // Reset state
        #23;
        chk("rst_trg_o", ifc.trg_o, 4'h0);
        chk("rst_busy_o", ifc.busy_o, 4'h0);
        chk("rst_acc", ifc.acc_cnt_o, 16'h0);
        chk("rst_rej", ifc.rej_cnt_o, 16'h0);
        #4 rst_n = 1'b1;
        tick();

        // Level mode W=4 D=3, one-cycle trigger on channel 0
        ifc.trg_i = 4'b0001;
        tick();
        ifc.trg_i = 4'b0000;
        chk("lvl_acc_k", acc_of(0), 4'd1);
        chk("lvl_trg_k", ifc.trg_o, 4'h0);
        for (int i = 1; i <= 8; i++) begin
            tick();
            chk($sformatf("lvl_trg_%0d", i), ifc.trg_o, (i <= 4) ? 4'b0001 : 4'b0000);
            chk($sformatf("lvl_busy_%0d", i), ifc.busy_o, (i <= 7) ? 4'b0001 : 4'b0000);
        end
        chk("lvl_acc", acc_of(0), 4'd1);
        chk("lvl_rej", rej_of(0), 4'd0);

        // Edge mode W=2 D=5 on channel 1: accept, reject, accept
        clear_counters();
        chk("clr_acc", ifc.acc_cnt_o, 16'h0);
        ifc.edge_mode_i = 1'b1;
        ifc.width_i     = 8'd2;
        ifc.dead_i      = 8'd5;
        ifc.trg_i = 4'b0010;
        tick();                                   // edge k
        ifc.trg_i = 4'b0000;
        chk("edg_acc_k", acc_of(1), 4'd1);
        tick();                                   // k+1
        chk("edg_trg_k1", ifc.trg_o, 4'b0010);
        tick();                                   // k+2
        chk("edg_trg_k2", ifc.trg_o, 4'b0010);
        ifc.trg_i = 4'b0010;
        tick();                                   // k+3: rejected edge
        ifc.trg_i = 4'b0000;
        chk("edg_trg_k3", ifc.trg_o, 4'b0000);
        chk("edg_busy_k3", ifc.busy_o, 4'b0010);
        chk("edg_rej_k3", rej_of(1), 4'd1);
        chk("edg_acc_k3", acc_of(1), 4'd1);
        repeat (4) tick();                        // k+7
        chk("edg_busy_k7", ifc.busy_o, 4'b0010);
        ifc.trg_i = 4'b0010;
        tick();                                   // k+8: accepted
        ifc.trg_i = 4'b0000;
        chk("edg_busy_k8", ifc.busy_o, 4'b0000);
        chk("edg_acc_k8", acc_of(1), 4'd2);
        tick();                                   // k+9
        chk("edg_trg_k9", ifc.trg_o, 4'b0010);
        chk("edg_busy_k9", ifc.busy_o, 4'b0010);
        repeat (8) tick();
        chk("edg_idle", ifc.busy_o, 4'b0000);
        chk("edg_rej_end", rej_of(1), 4'd1);

        // width=0 dead=0 level mode, channel 2 held high 10 cycles
        clear_counters();
        chk("clr_rej", ifc.rej_cnt_o, 16'h0);
        ifc.edge_mode_i = 1'b0;
        ifc.width_i     = 8'd0;
        ifc.dead_i      = 8'd0;
        ifc.trg_i       = 4'b0100;
        for (int j = 0; j < 10; j++) begin
            tick();
            chk($sformatf("w0_trg_%0d", j), ifc.trg_o, (j % 2 == 1) ? 4'b0100 : 4'b0000);
        end
        ifc.trg_i = 4'b0000;
        tick();
        chk("w0_trg_end", ifc.trg_o, 4'b0000);
        chk("w0_acc", acc_of(2), 4'd5);
        chk("w0_rej", rej_of(2), 4'd0);

        // Simultaneous edges, en=0101
        clear_counters();
        ifc.edge_mode_i = 1'b1;
        ifc.en_i        = 4'b0101;
        ifc.width_i     = 8'd1;
        ifc.trg_i       = 4'hF;
        tick();
        ifc.trg_i = 4'h0;
        chk("sim_acc0", acc_of(0), 4'd1);
        chk("sim_acc2", acc_of(2), 4'd1);
        tick();
        chk("sim_trg", ifc.trg_o, 4'b0101);
        chk("sim_busy", ifc.busy_o, 4'b0101);
        tick();
        chk("sim_trg_end", ifc.trg_o, 4'b0000);
        chk("sim_acc1", acc_of(1), 4'd0);
        chk("sim_rej1", rej_of(1), 4'd0);
        chk("sim_acc3", acc_of(3), 4'd0);
        chk("sim_rej3", rej_of(3), 4'd0);

        // Saturation: 20 accepts on channel 3 with 4-bit counters
        clear_counters();
        ifc.en_i = 4'hF;
        for (int i = 0; i < 20; i++) begin
            ifc.trg_i = 4'b1000;
            tick();
            ifc.trg_i = 4'b0000;
            tick();
        end
        chk("sat_acc", acc_of(3), 4'd15);
        chk("sat_rej", rej_of(3), 4'd0);
        // Clear in the same cycle as an accept: clear wins, FSM still runs
        ifc.trg_i     = 4'b1000;
        ifc.cnt_clr_i = 1'b1;
        tick();
        ifc.trg_i     = 4'b0000;
        ifc.cnt_clr_i = 1'b0;
        chk("clr_acc_same", acc_of(3), 4'd0);
        tick();
        chk("clr_trg_same", ifc.trg_o, 4'b1000);
        repeat (2) tick();

        // Reset mid-pulse
        clear_counters();
        ifc.edge_mode_i = 1'b0;
        ifc.width_i     = 8'd4;
        ifc.dead_i      = 8'd3;
        ifc.trg_i       = 4'b0001;
        tick();
        ifc.trg_i = 4'b0000;
        tick();
        tick();
        chk("rmid_trg_pre", ifc.trg_o, 4'b0001);
        chk("rmid_acc_pre", acc_of(0), 4'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rmid_trg", ifc.trg_o, 4'b0000);
        chk("rmid_busy", ifc.busy_o, 4'b0000);
        chk("rmid_acc", ifc.acc_cnt_o, 16'h0);
        #2 rst_n = 1'b1;
        ifc.trg_i = 4'b0001;
        tick();
        ifc.trg_i = 4'b0000;
        chk("rpost_acc", acc_of(0), 4'd1);
        tick();
        chk("rpost_trg", ifc.trg_o, 4'b0001);
        chk("rpost_busy", ifc.busy_o, 4'b0001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
